mux_nx1_stream_rr: RTL and testbench

- Parametrised N-input to 1-output stream multiplexer with valid/ready handshakes on every port and a registered output stage.
- Two modes, chosen at run time: static select (sel picks the channel) and fair round-robin arbitration across all valid inputs.
- Sits between multiple producers and one consumer. It is the sequential, multi-channel generalisation of the team's 2:1 gate-level mux.

---
 rtl/mux_nx1_stream_rr.sv | 85 ++++++++
 tb/tb_mux_nx1_stream_rr.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_stream_rr.sv
// mux_nx1_stream_rr: N-input to 1-output valid/ready stream mux with a registered output stage.
//   Two run-time modes: static select (sel picks the channel) or fair round-robin across valid inputs.
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_data    N*W packed channel data, channel i at [i*W +: W]
//     in_valid   per-channel valid
//     in_ready   per-channel ready (combinational, one-hot or zero)
//     mode       0 = static select, 1 = round-robin
//     sel        channel index used in static mode (out-of-range selects nothing)
//     out_data   registered data word
//     out_ch     index of the channel that supplied out_data
//     out_valid  registered valid
//     out_ready  consumer ready
module mux_nx1_stream_rr #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_ch,
    output logic            out_valid,
    input  logic            out_ready
);
    logic [SELW-1:0] ptr, rr_grant, grant;
    logic            rr_v, st_v, grant_v, load, xfer;
    logic [W-1:0]    grant_data;

    // Round-robin pick: the valid channel with the smallest forward distance from ptr wins.
    always_comb begin
        int best;
        int d;
        best     = N;
        d        = 0;
        rr_grant = '0;
        st_v     = 1'b0;
        for (int i = 0; i < N; i++) begin
            d = (i + N - int'(ptr)) % N;
            if (in_valid[i] && d < best) begin
                best     = d;
                rr_grant = SELW'(i);
            end
            if (sel == SELW'(i)) st_v = in_valid[i];
        end
        rr_v = best < N;
    end

    assign grant   = mode ? rr_grant : sel;
    assign grant_v = mode ? rr_v : st_v;
    assign load    = ~out_valid | out_ready;

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = rst_n & load & grant_v & (grant == SELW'(i));
            if (grant == SELW'(i)) grant_data = in_data[i*W +: W];
        end
    end

    assign xfer = |(in_ready & in_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_ch    <= grant;
            if (mode) ptr <= (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_nx1_stream_rr.sv
// tb_mux_nx1_stream_rr: directed and randomized checks of mux_nx1_stream_rr against a behavioural model.
module tb_mux_nx1_stream_rr;
    localparam int N    = 4;
    localparam int W    = 8;
    localparam int SELW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SELW-1:0] sel;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_ch;
    logic            out_valid;
    logic            out_ready;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    int       m_ptr;
    logic     m_ov;
    logic [W-1:0] m_od;
    int       m_och;

    mux_nx1_stream_rr #(.N(N), .W(W), .SELW(SELW)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic m_reset;
        m_ptr = 0;
        m_ov  = 1'b0;
        m_od  = '0;
        m_och = 0;
    endtask

    // Expected grant index from the rules, -1 when nothing may transfer.
    function automatic int exp_grant();
        int g;
        int s;
        g = -1;
        s = int'(sel);
        if (!rst_n || (m_ov && !out_ready)) return -1;
        if (!mode) begin
            if (s < N && in_valid[s]) g = s;
        end else begin
            for (int k = 0; k < N; k++)
                if (g < 0 && in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        return g;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        g = exp_grant();
        return (g < 0) ? '0 : N'(1 << g);
    endfunction

    // One clock: model advances with the inputs present before the edge, then settles 1 time unit after.
    task automatic tick;
        int g;
        g = exp_grant();
        @(posedge clk);
        if (g >= 0) begin
            m_ov  = 1'b1;
            m_od  = in_data[g*W +: W];
            m_och = g;
            if (mode) m_ptr = (g + 1) % N;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        m_reset();
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 4'hF; mode = 1'b1; out_ready = 1'b1; sel = '0;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (out_ch !== 3'd0) begin failures++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch); end
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_grant got=%b exp=0001", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_ch !== 3'd0 || out_data !== 8'h10) begin
            failures++; $display("FAIL reset_first_word got=%b/%0d/%h exp=1/0/10", out_valid, out_ch, out_data); end
        tick();
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 3'd0) begin
            failures++; $display("FAIL reset_async got=%b/%0d/%h exp=0/0/00", out_valid, out_ch, out_data); end
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_async_ready got=%b exp=0000", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL reset_ptr_restart got=%b exp=0001", in_ready); end
    endtask

    task automatic test_static;
        do_reset();
        mode = 1'b0; sel = 3'd2; in_valid = 4'b0110; out_ready = 1'b1;
        in_data = {8'h44, 8'hA5, 8'h5A, 8'h00};
        #1;
        checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL static_ready got=%b exp=0100", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_ch !== 3'd2 || out_data !== 8'hA5) begin
            failures++; $display("FAIL static_word got=%b/%0d/%h exp=1/2/a5", out_valid, out_ch, out_data); end
        for (int c = 0; c < 4; c++) begin
            in_data[2*W +: W] = W'(8'hB0 + c);
            #1;
            checks++; if (in_ready[1] !== 1'b0) begin failures++; $display("FAIL static_ch1_granted cyc=%0d got=%b exp=0", c, in_ready[1]); end
            tick();
            checks++; if (out_ch !== 3'd2 || out_data !== W'(8'hB0 + c)) begin
                failures++; $display("FAIL static_seq cyc=%0d got=%0d/%h exp=2/%h", c, out_ch, out_data, 8'hB0 + c); end
        end
    endtask

    task automatic test_rr_fair;
        do_reset();
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_ch !== 3'(c % N) || out_data !== W'(8'h10 + c % N)) begin
                failures++; $display("FAIL rr_fair cyc=%0d got=%b/%0d/%h exp=1/%0d/%h", c, out_valid, out_ch, out_data, c % N, 8'h10 + c % N); end
        end
    endtask

    task automatic test_rr_skip_wrap;
        int exp_seq[4] = '{0, 2, 0, 2};
        mode = 1'b1; out_ready = 1'b1;
        in_valid = 4'b0100;
        tick();
        checks++; if (out_ch !== 3'd2) begin failures++; $display("FAIL rr_setup got=%0d exp=2", out_ch); end
        in_valid = 4'b0101;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (in_ready !== N'(1 << exp_seq[c])) begin
                failures++; $display("FAIL rr_skip_ready cyc=%0d got=%b exp=%b", c, in_ready, N'(1 << exp_seq[c])); end
            tick();
            checks++; if (out_ch !== 3'(exp_seq[c])) begin
                failures++; $display("FAIL rr_skip_ch cyc=%0d got=%0d exp=%0d", c, out_ch, exp_seq[c]); end
        end
    endtask

    task automatic test_back_pressure;
        mode = 1'b0; sel = 3'd0; in_valid = 4'b0001; out_ready = 1'b1;
        in_data = {8'h00, 8'h00, 8'h00, 8'h3C};
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = N'($urandom);
            in_data  = $urandom;
            mode     = 1'($urandom);
            sel      = 3'($urandom_range(0, 3));
            #1;
            checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=0000", c, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
                failures++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/3c", c, out_valid, out_data); end
        end
        out_ready = 1'b1; mode = 1'b0; sel = 3'd1; in_valid = 4'b0010;
        in_data = {8'h00, 8'h00, 8'hC3, 8'h00};
        #1;
        checks++; if (in_ready !== 4'b0010) begin failures++; $display("FAIL bp_release_ready got=%b exp=0010", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hC3 || out_ch !== 3'd1) begin
            failures++; $display("FAIL bp_no_bubble got=%b/%0d/%h exp=1/1/c3", out_valid, out_ch, out_data); end
        in_valid = 4'b0000;
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 8'hC3) begin
            failures++; $display("FAIL drain_empty got=%b/%h exp=0/c3", out_valid, out_data); end
    endtask

    task automatic test_out_of_range;
        do_reset();
        mode = 1'b0; sel = 3'd5; in_valid = 4'hF; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL oor_ready cyc=%0d got=%b exp=0000", c, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL oor_valid cyc=%0d got=%b exp=0", c, out_valid); end
        end
    endtask

    task automatic test_random;
        logic [N-1:0] er;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid  = N'($urandom);
            in_data   = $urandom;
            mode      = ($urandom_range(0, 3) != 0);
            sel       = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            er = exp_ready();
            checks++; if (in_ready !== er) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, in_ready, er); end
            tick();
            checks++; if (out_valid !== m_ov || out_data !== m_od || out_ch !== 3'(m_och)) begin
                failures++; $display("FAIL rand_out cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, out_valid, out_ch, out_data, m_ov, m_och, m_od); end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
        m_reset();
        test_reset();
        test_static();
        test_rr_fair();
        test_rr_skip_wrap();
        test_back_pressure();
        test_out_of_range();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
